// File: rtl/profile_readout_if.sv
// rtl/profile_readout_if.sv - register bus between the CPU peripheral bus and profile_readout
interface profile_readout_if;
    logic [4:0]  address;
    logic        readEnable;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        done;
    logic        busy;

    modport master (
        output address, readEnable, writeEnable, writeData,
        input  readData, done, busy
    );

    modport slave (
        input  address, readEnable, writeEnable, writeData,
        output readData, done, busy
    );
endinterface

// File: rtl/profile_readout.sv
// rtl/profile_readout.sv - control and tear-free readout of four 64-bit profile counters
module profile_readout #(
    parameter int          NR_OF_COUNTERS = 4,
    parameter logic [31:0] RESET_MASK     = 32'h00000000
) (
    input  logic                           clock,
    input  logic                           reset,
    profile_readout_if.slave               bus,
    input  logic [64*NR_OF_COUNTERS-1:0]   counterValues,
    output logic [32*NR_OF_COUNTERS-1:0]   counterMasks,
    output logic [NR_OF_COUNTERS-1:0]      counterEnabled,
    output logic [NR_OF_COUNTERS-1:0]      counterPaused,
    output logic [NR_OF_COUNTERS-1:0]      resetCounter
);
    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    state_t      state;
    logic [1:0]  reqIndex;
    logic [2:0]  reqReg;
    logic [1:0]  snapIndex;
    logic [31:0] snapLo;
    logic [31:0] snapHi1;
    logic [31:0] snapHi [NR_OF_COUNTERS];
    logic [31:0] readDataReg;
    logic        doneReg;
    logic [63:0] reqValue;
    logic [63:0] snapValue;

    assign reqIndex  = bus.address[4:3];
    assign reqReg    = bus.address[2:0];
    assign reqValue  = counterValues[{reqIndex, 6'b0} +: 64];
    assign snapValue = counterValues[{snapIndex, 6'b0} +: 64];

    assign bus.readData = readDataReg;
    assign bus.done     = doneReg;
    assign bus.busy     = (state != IDLE);

    // Request decode, register file and the low-snapshot / high-recheck sequence.
    // The high word lags a low-word wrap by one cycle, so WAIT gives it time to
    // settle before CHECK compares it against the captured copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            snapIndex      <= '0;
            snapLo         <= '0;
            snapHi1        <= '0;
            readDataReg    <= '0;
            doneReg        <= 1'b0;
            counterMasks   <= {NR_OF_COUNTERS{RESET_MASK}};
            counterEnabled <= '0;
            counterPaused  <= '0;
            resetCounter   <= '0;
            for (int i = 0; i < NR_OF_COUNTERS; i++) begin
                snapHi[i] <= '0;
            end
        end else begin
            doneReg      <= 1'b0;
            resetCounter <= '0;
            case (state)
                IDLE: begin
                    if (bus.writeEnable) begin
                        doneReg     <= 1'b1;
                        readDataReg <= '0;
                        case (reqReg)
                            3'd0: begin
                                counterEnabled[reqIndex] <= bus.writeData[0];
                                counterPaused[reqIndex]  <= bus.writeData[1];
                                resetCounter[reqIndex]   <= bus.writeData[2];
                            end
                            3'd1: counterMasks[{reqIndex, 5'b0} +: 32] <= bus.writeData;
                            default: ;
                        endcase
                    end else if (bus.readEnable) begin
                        if (reqReg == 3'd2) begin
                            snapLo    <= reqValue[31:0];
                            snapHi1   <= reqValue[63:32];
                            snapIndex <= reqIndex;
                            state     <= WAIT;
                        end else begin
                            doneReg <= 1'b1;
                            case (reqReg)
                                3'd0:    readDataReg <= {30'b0, counterPaused[reqIndex], counterEnabled[reqIndex]};
                                3'd1:    readDataReg <= counterMasks[{reqIndex, 5'b0} +: 32];
                                3'd3:    readDataReg <= snapHi[reqIndex];
                                default: readDataReg <= '0;
                            endcase
                        end
                    end
                end
                WAIT: state <= CHECK;
                CHECK: begin
                    if (snapValue[63:32] == snapHi1) begin
                        snapHi[snapIndex] <= snapHi1;
                        readDataReg       <= snapLo;
                        doneReg           <= 1'b1;
                        state             <= IDLE;
                    end else begin
                        snapLo  <= snapValue[31:0];
                        snapHi1 <= snapValue[63:32];
                        state   <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_profile_readout.sv
// tb/tb_profile_readout.sv - self-checking bench for profile_readout
module tb_profile_readout;
    localparam logic [31:0] RESET_MASK = 32'h00000000;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] counterValues = '0;
    logic [127:0] counterMasks;
    logic [3:0]   counterEnabled;
    logic [3:0]   counterPaused;
    logic [3:0]   resetCounter;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    profile_readout_if bus();

    profile_readout #(
        .NR_OF_COUNTERS(4),
        .RESET_MASK(RESET_MASK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .counterValues(counterValues),
        .counterMasks(counterMasks),
        .counterEnabled(counterEnabled),
        .counterPaused(counterPaused),
        .resetCounter(resetCounter)
    );

    always #5 clock = ~clock;

    // Drive one single-cycle request; returns 1ns into the cycle after acceptance.
    task automatic sendReq(input logic [4:0] a, input logic re, input logic we, input logic [31:0] d);
        @(posedge clock); #1;
        bus.address     = a;
        bus.readEnable  = re;
        bus.writeEnable = we;
        bus.writeData   = d;
        @(posedge clock); #1;
        bus.readEnable  = 1'b0;
        bus.writeEnable = 1'b0;
        bus.writeData   = '0;
    endtask

    // Observe the next done pulse, bounded; lat counts cycles after acceptance.
    task automatic waitDone(output int lat, output logic [31:0] data);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        data = bus.readData;
    endtask

    task automatic test_reset();
        int          lat;
        logic [31:0] data;
        exp_t        e;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        total++;
        if ({bus.done, bus.busy, resetCounter, counterEnabled, counterPaused} !== 14'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got done=%b busy=%b rc=%b en=%b pa=%b want all 0",
                     bus.done, bus.busy, resetCounter, counterEnabled, counterPaused);
        end
        total++;
        if (counterMasks !== {4{RESET_MASK}} || bus.readData !== 32'h0) begin
            bad++;
            $display("FAIL reset_mask: got masks=%h rd=%h want masks=%h rd=0",
                     counterMasks, bus.readData, {4{RESET_MASK}});
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 2; r++) begin
                sb.push_back('{data: (r == 0) ? 32'h0 : RESET_MASK, lat: 1});
                sendReq({c[1:0], r[2:0]}, 1'b1, 1'b0, 32'h0);
                waitDone(lat, data);
                e = sb.pop_front();
                total++;
                if (lat !== e.lat) begin
                    bad++;
                    $display("FAIL reset_read_lat c%0d r%0d: got %0d want %0d", c, r, lat, e.lat);
                end
                total++;
                if (data !== e.data) begin
                    bad++;
                    $display("FAIL reset_read_data c%0d r%0d: got %h want %h", c, r, data, e.data);
                end
            end
        end
    endtask

    task automatic test_control();
        int          lat;
        logic [31:0] data;
        exp_t        e;
        sb.push_back('{data: 32'h0, lat: 1});
        sendReq(5'h08, 1'b0, 1'b1, 32'h3);
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL ctrl_write1: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
        total++;
        if (counterEnabled !== 4'b0010 || counterPaused !== 4'b0010) begin
            bad++;
            $display("FAIL ctrl_bits: got en=%b pa=%b want 0010 0010", counterEnabled, counterPaused);
        end
        sb.push_back('{data: 32'h0, lat: 1});
        sendReq(5'h08, 1'b0, 1'b1, 32'h4);
        total++;
        if (resetCounter !== 4'b0010 || counterEnabled !== 4'b0 || counterPaused !== 4'b0) begin
            bad++;
            $display("FAIL ctrl_reset_pulse: got rc=%b en=%b pa=%b want 0010 0000 0000",
                     resetCounter, counterEnabled, counterPaused);
        end
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL ctrl_write2: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
        @(posedge clock); #1;
        total++;
        if (resetCounter !== 4'b0) begin
            bad++;
            $display("FAIL ctrl_pulse_width: got rc=%b want 0000", resetCounter);
        end
    endtask

    task automatic test_mask();
        int          lat;
        logic [31:0] data;
        exp_t        e;
        // read and write together: the write wins
        sb.push_back('{data: 32'h0, lat: 1});
        sendReq(5'h11, 1'b1, 1'b1, 32'hA5A5_0001);
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL mask_write: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
        total++;
        if (counterMasks[95:64] !== 32'hA5A5_0001 || counterMasks[63:0] !== {2{RESET_MASK}}) begin
            bad++;
            $display("FAIL mask_port: got %h want a5a50001 in counter 2 only", counterMasks);
        end
        sb.push_back('{data: 32'hA5A5_0001, lat: 1});
        sendReq(5'h11, 1'b1, 1'b0, 32'h0);
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL mask_readback: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
        sb.push_back('{data: 32'h0, lat: 1});
        sendReq(5'h15, 1'b1, 1'b0, 32'h0);
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL reserved_read: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
    endtask

    task automatic test_snapshot();
        int          lat;
        logic [31:0] data;
        exp_t        e;
        counterValues[63:0] = 64'h0000_0007_1234_5678;
        sb.push_back('{data: 32'h1234_5678, lat: 3});
        sendReq(5'h02, 1'b1, 1'b0, 32'h0);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL snap_busy: got %b want 1", bus.busy);
        end
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL snap_read: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL snap_busy_done: got %b want 0", bus.busy);
        end
        sb.push_back('{data: 32'h0000_0007, lat: 1});
        sendReq(5'h03, 1'b1, 1'b0, 32'h0);
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL snap_hi: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
    endtask

    task automatic test_retry();
        int          lat;
        logic [31:0] data;
        exp_t        e;
        counterValues[255:192] = 64'h0;
        sb.push_back('{data: 32'h0, lat: 5});
        sendReq(5'h1A, 1'b1, 1'b0, 32'h0);
        counterValues[255:192] = 64'h0000_0001_0000_0000;
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL retry_read: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
        sb.push_back('{data: 32'h1, lat: 1});
        sendReq(5'h1B, 1'b1, 1'b0, 32'h0);
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL retry_hi: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
    endtask

    task automatic test_busy_and_reset();
        int          lat;
        int          doneCount;
        int          doneLat;
        logic [31:0] data;
        logic [31:0] doneData;
        exp_t        e;
        sb.push_back('{data: 32'h1234_5678, lat: 3});
        sendReq(5'h02, 1'b1, 1'b0, 32'h0);
        bus.address    = 5'h00;
        bus.readEnable = 1'b1;
        @(posedge clock); #1;
        bus.readEnable = 1'b0;
        lat = 2;
        doneCount = 0;
        doneLat = 0;
        doneData = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) begin
                doneCount++;
                doneLat  = lat;
                doneData = bus.readData;
            end
            @(posedge clock); #1;
            lat++;
        end
        e = sb.pop_front();
        total++;
        if (doneCount !== 1) begin
            bad++;
            $display("FAIL drop_count: got %0d done pulses want 1", doneCount);
        end
        total++;
        if (doneLat !== e.lat || doneData !== e.data) begin
            bad++;
            $display("FAIL drop_snap: got lat=%0d rd=%h want lat=%0d rd=%h", doneLat, doneData, e.lat, e.data);
        end

        sendReq(5'h10, 1'b0, 1'b1, 32'h3);
        sendReq(5'h01, 1'b0, 1'b1, 32'hDEAD_BEEF);
        sendReq(5'h02, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) doneCount++;
            @(posedge clock); #1;
        end
        total++;
        if (doneCount !== 0) begin
            bad++;
            $display("FAIL reset_mid: got %0d cycles with done/busy want 0", doneCount);
        end
        total++;
        if (counterMasks !== {4{RESET_MASK}} || counterEnabled !== 4'b0 || counterPaused !== 4'b0
            || resetCounter !== 4'b0 || bus.readData !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got masks=%h en=%b pa=%b rc=%b rd=%h want reset values",
                     counterMasks, counterEnabled, counterPaused, resetCounter, bus.readData);
        end
        sb.push_back('{data: 32'h0, lat: 1});
        sendReq(5'h03, 1'b1, 1'b0, 32'h0);
        waitDone(lat, data);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat || data !== e.data) begin
            bad++;
            $display("FAIL reset_snaphi: got lat=%0d rd=%h want lat=%0d rd=%h", lat, data, e.lat, e.data);
        end
    endtask

    initial begin
        bus.address     = '0;
        bus.readEnable  = 1'b0;
        bus.writeEnable = 1'b0;
        bus.writeData   = '0;
        test_reset();
        test_control();
        test_mask();
        test_snapshot();
        test_retry();
        test_busy_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/profile_readout.md
Name: profile_readout

Overview:
Bus-side controller and reader for a bank of four 64-bit profile counters. It drives each counter's mask, enable, pause and reset, and returns counter values over a 32-bit register interface. The counter's high word updates one cycle after its low word wraps. To avoid torn reads, the block takes a low-word snapshot, re-checks the high word, and retries if it changed. The block sits between the CPU peripheral bus and the counter instances.

Parameters:
NR_OF_COUNTERS, 4, number of counters controlled; fixed at 4 (the address field is 2 bits).
RESET_MASK, 32'h00000000, reset value of every counterMask register.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
address  input  5  bits [4:3] select the counter; bits [2:0] select the register (0 control, 1 mask, 2 value low, 3 value high, 4..7 reserved)
readEnable  input  1  single-cycle read request
writeEnable  input  1  single-cycle write request
writeData  input  32  write data
readData  output  32  read data; valid while done=1
done  output  1  one-cycle completion pulse, issued for every accepted request
busy  output  1  high while the snapshot FSM is not IDLE
counterValues  input  256  counter i value on bits [64i+63:64i]
counterMasks  output  128  counter i mask on bits [32i+31:32i]
counterEnabled  output  4  per-counter enable
counterPaused  output  4  per-counter pause
resetCounter  output  4  per-counter synchronous reset pulse

Behaviour:
- Reset state: all registers cleared, masks set to RESET_MASK, resetCounter=0, done=0, readData=0, FSM in IDLE, every snapHi register cleared.
- Request acceptance:
  - A request is accepted only when the FSM is IDLE.
  - Requests arriving while busy=1 are dropped, with no done pulse.
  - If readEnable and writeEnable are high together, the request is a write and the read is ignored.
- Control register (reg 0):
  - Write: bit0 sets counterEnabled[i]; bit1 sets counterPaused[i].
  - Write with bit2=1: resetCounter[i] goes high for exactly the next cycle. The enable and pause bits are still written from bits 0 and 1.
  - Read: returns {29'b0, 1'b0, paused, enabled}.
- Mask register (reg 1): read/write of counterMasks[i].
- Writes, and reads of regs 0, 1, 3 and 4..7: done=1 and readData valid in the cycle after acceptance (1-cycle latency).
  - Writes return readData=0.
  - Reserved registers read as 0; writes to them are ignored, but done still pulses.
- Reg 3 read: returns snapHi[i], the high word captured by the last completed reg 2 read of counter i. It does not sample live.
- Reg 2 read, snapshot FSM:
  - IDLE: on acceptance, capture lo=value[31:0] and hi1=value[63:32] of counter i, latch the index, go to WAIT.
  - WAIT: one cycle, no action, go to CHECK.
  - CHECK, live value[63:32]==hi1: snapHi[i]<=hi1, readData<=lo, done=1 in the next cycle, go to IDLE.
  - CHECK, mismatch: recapture lo and hi1 from the live value, go to WAIT.
  - Retries are unbounded; at most one retry is possible per low-word wrap.
- Snapshot latency: done 3 cycles after acceptance with no retry; each retry adds 2 cycles.
- busy is high in WAIT and CHECK and low in IDLE, including the done cycle.
- Reset asserted mid-operation: the FSM returns to IDLE, no done pulse is issued, and a pending resetCounter pulse is cancelled.
- done and resetCounter are registered pulses, never combinational from the inputs.

Test Plan:
1. Reset, then read reg 0 and reg 1 of each counter -> readData=0 and RESET_MASK respectively; done one cycle after each request.
2. Write 0x3 then 0x4 to addr 0x08 (counter 1 control) -> counterEnabled=4'b0010, counterPaused=4'b0010; then resetCounter[1] high for one cycle with enable and pause cleared.
3. Write 0xA5A5_0001 to addr 0x11 (counter 2 mask) -> counterMasks[95:64]=0xA5A50001; read back returns the same value.
4. Counter 0 value 0x0000_0007_1234_5678 held stable; read addr 0x02 -> done 3 cycles later with readData=0x12345678; a following read of addr 0x03 returns 0x00000007.
5. Counter 3 low word wraps at the capture edge (live 0x0000_0000_0000_0000, then high word becomes 0x1 one cycle later) -> CHECK mismatches, one retry, done after 5 cycles; the reg 3 read returns 0x1.
6. Pulse readEnable during busy, and assert reset in WAIT -> the dropped request gives no done; after reset, busy=0, done=0 and all outputs are at reset values.
